stream_vec_packer: RTL and testbench

STREAM_VEC_PACKER -- requirements
Module: stream_vec_packer

---
 rtl/stream_vec_packer_pkg.sv | 14 +
 rtl/stream_vec_packer_if.sv | 29 ++
 rtl/stream_vec_packer.sv | 108 ++++++++++
 tb/tb_stream_vec_packer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_vec_packer_pkg.sv
// Shared SFU definitions: packer state encoding and the FP16 constants
// used by the vector packer.
package stream_vec_packer_pkg;

  // FILL collects elements into lanes, HOLD presents the packed vector.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

  // FP16 +0.0, the default fill value for lanes with no real element.
  localparam logic [15:0] FP16_ZERO = 16'h0000;

endpackage

// File: rtl/stream_vec_packer_if.sv
// Handshake bundle for the vector packer: element stream in, packed vector out.
// The slave modport is the packer's view; master is the surrounding logic.
interface stream_vec_packer_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned CW = $clog2(N + 1);

  logic               s_tvalid;
  logic               s_tready;
  logic [WIDTH-1:0]   s_tdata;
  logic               s_tlast;
  logic               m_valid;
  logic               m_ready;
  logic [N*WIDTH-1:0] m_vec;
  logic               m_last;
  logic [CW-1:0]      m_count;

  modport slave (
    input  s_tvalid, s_tdata, s_tlast, m_ready,
    output s_tready, m_valid, m_vec, m_last, m_count
  );

  modport master (
    output s_tvalid, s_tdata, s_tlast, m_ready,
    input  s_tready, m_valid, m_vec, m_last, m_count
  );

endinterface

// File: rtl/stream_vec_packer.sv
// Packs a stream of scalar elements into N-lane vectors for the adder tree.
// A vector closes when lane N-1 is written or an element carries tlast;
// unused lanes are left at PAD and m_count reports the real lane count.
module stream_vec_packer
  import stream_vec_packer_pkg::*;
#(
  parameter int unsigned     N     = 4,
  parameter int unsigned     WIDTH = 16,
  parameter logic [WIDTH-1:0] PAD  = WIDTH'(FP16_ZERO)
) (
  input  logic                clk,
  input  logic                rst,
  stream_vec_packer_if.slave  bus
);

  localparam int unsigned LW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(N + 1);

  typedef logic [N-1:0][WIDTH-1:0] lanes_t;

  pack_state_t   state_q, state_d;
  logic [LW-1:0] lane_q,  lane_d;
  lanes_t        vec_q,   vec_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_q,  last_d;
  logic          run_q;
  logic          s_ready;

  // Accept in FILL; in HOLD only when the pending vector leaves this cycle.
  // run_q keeps s_tready low until the first edge after reset release.
  always_comb begin
    s_ready = run_q && ((state_q == FILL) || bus.m_ready);
  end

  assign bus.s_tready = s_ready;
  assign bus.m_valid  = (state_q == HOLD);
  assign bus.m_vec    = vec_q;
  assign bus.m_count  = count_q;
  assign bus.m_last   = last_q;

  // Next-state: lane writes, vector close, and the consume/refill overlap.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    vec_d   = vec_q;
    count_d = count_q;
    last_d  = last_q;
    case (state_q)
      FILL: begin
        if (bus.s_tvalid && s_ready) begin
          vec_d[lane_q] = bus.s_tdata;
          if ((lane_q == LW'(N - 1)) || bus.s_tlast) begin
            state_d = HOLD;
            lane_d  = '0;
            count_d = CW'(lane_q) + CW'(1);
            last_d  = bus.s_tlast;
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
      end
      HOLD: begin
        if (bus.m_ready) begin
          // Vector leaves: start a fresh PAD-preset vector; an element
          // arriving in the same cycle lands in lane 0 of it.
          vec_d   = {N{PAD}};
          lane_d  = '0;
          count_d = '0;
          last_d  = 1'b0;
          state_d = FILL;
          if (bus.s_tvalid && s_ready) begin
            vec_d[0] = bus.s_tdata;
            if ((N == 1) || bus.s_tlast) begin
              state_d = HOLD;
              count_d = CW'(1);
              last_d  = bus.s_tlast;
            end else begin
              lane_d = LW'(1);
            end
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State, lane counter and vector registers; reset discards any partial vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      lane_q  <= '0;
      vec_q   <= {N{PAD}};
      count_q <= '0;
      last_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      vec_q   <= vec_d;
      count_q <= count_d;
      last_q  <= last_d;
      run_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_vec_packer.sv
// Self-checking bench for stream_vec_packer (N=4, FP16 lanes).
// Reference: elements of the open group are kept in a queue; a closed group
// becomes an expected vector that must be presented until consumed.
module tb_stream_vec_packer;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  typedef struct packed {
    logic [63:0] vec;
    logic [2:0]  cnt;
    logic        last;
  } exp_t;

  logic clk;
  logic rst;

  stream_vec_packer_if #(.N(N), .WIDTH(W)) bus ();

  stream_vec_packer #(.N(N), .WIDTH(W), .PAD(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [15:0] grp[$];
  exp_t        expq[$];
  logic        alive;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  function automatic exp_t close_group(input logic last);
    exp_t e;
    e.vec  = '0;
    for (int i = 0; i < grp.size(); i++) e.vec[i*16 +: 16] = grp[i];
    e.cnt  = 3'(grp.size());
    e.last = last;
    return e;
  endfunction

  // One clock cycle: drive inputs, check at the falling edge, predict the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic l, input logic mr);
    logic exp_mv, exp_rdy;
    bus.s_tvalid = v;
    bus.s_tdata  = d;
    bus.s_tlast  = l;
    bus.m_ready  = mr;
    @(negedge clk);
    exp_mv  = rst && (expq.size() > 0);
    exp_rdy = alive && ((expq.size() == 0) || mr);
    chk("m_valid", 64'(bus.m_valid), 64'(exp_mv));
    chk("s_tready", 64'(bus.s_tready), 64'(exp_rdy));
    if (exp_mv) begin
      chk("m_vec", bus.m_vec, expq[0].vec);
      chk("m_count", 64'(bus.m_count), 64'(expq[0].cnt));
      chk("m_last", 64'(bus.m_last), 64'(expq[0].last));
      if (mr) void'(expq.pop_front());
    end
    if (exp_rdy && v) begin
      grp.push_back(d);
      if ((grp.size() == N) || l) begin
        expq.push_back(close_group(l));
        grp.delete();
      end
    end
    @(posedge clk);
    alive = rst;
    #1;
  endtask

  task automatic do_reset(input int unsigned cycles);
    rst = 1'b0;
    bus.s_tvalid = 1'b1;
    bus.m_ready  = 1'b1;
    #1;
    grp.delete();
    expq.delete();
    alive = 1'b0;
    chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
    chk("rst_s_tready", 64'(bus.s_tready), 64'd0);
    chk("rst_m_count", 64'(bus.m_count), 64'd0);
    chk("rst_m_last", 64'(bus.m_last), 64'd0);
    chk("rst_m_vec", bus.m_vec, 64'd0);
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic check_out(input string tag, input logic [63:0] vec, input logic [2:0] cnt,
                           input logic last);
    chk({tag, "_valid"}, 64'(bus.m_valid), 64'd1);
    chk({tag, "_vec"}, bus.m_vec, vec);
    chk({tag, "_count"}, 64'(bus.m_count), 64'(cnt));
    chk({tag, "_last"}, 64'(bus.m_last), 64'(last));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] seq[8];
    rst = 1'b0;
    alive = 1'b0;
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    bus.s_tlast  = 1'b0;
    bus.m_ready  = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);
    step(1'b1, 16'h1111, 1'b0, 1'b1);  // ignored: first cycle after release

    // Full vector, no tlast
    step(1'b1, 16'h3C00, 1'b0, 1'b1);
    step(1'b1, 16'h4000, 1'b0, 1'b1);
    step(1'b1, 16'h4200, 1'b0, 1'b1);
    step(1'b1, 16'h4400, 1'b0, 1'b1);
    check_out("full", 64'h4400_4200_4000_3C00, 3'd4, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // Backpressure for 5 cycles with an element waiting
    step(1'b1, 16'h3C00, 1'b0, 1'b0);
    step(1'b1, 16'h4000, 1'b0, 1'b0);
    step(1'b1, 16'h4200, 1'b0, 1'b0);
    step(1'b1, 16'h4400, 1'b0, 1'b0);
    repeat (5) begin
      step(1'b1, 16'h4500, 1'b0, 1'b0);
      chk("stall_tready", 64'(bus.s_tready), 64'd0);
    end
    check_out("stall", 64'h4400_4200_4000_3C00, 3'd4, 1'b0);
    step(1'b1, 16'h4500, 1'b0, 1'b1);
    step(1'b1, 16'h4600, 1'b0, 1'b0);
    step(1'b1, 16'h4700, 1'b0, 1'b0);
    step(1'b1, 16'h4800, 1'b0, 1'b0);
    check_out("after_stall", 64'h4800_4700_4600_4500, 3'd4, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // Short group closed by tlast
    step(1'b1, 16'h3C00, 1'b0, 1'b1);
    step(1'b1, 16'h4000, 1'b1, 1'b1);
    check_out("tlast", 64'h0000_0000_4000_3C00, 3'd2, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // Eight back-to-back elements, m_ready held high
    for (int i = 0; i < 8; i++) seq[i] = 16'(16'h5000 + i);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, seq[i], 1'b0, 1'b1);
      if (i == 3) check_out("b2b_first", {seq[3], seq[2], seq[1], seq[0]}, 3'd4, 1'b0);
      if (i == 4) chk("b2b_gap_valid", 64'(bus.m_valid), 64'd0);
    end
    check_out("b2b_second", {seq[7], seq[6], seq[5], seq[4]}, 3'd4, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // Reset mid-fill discards the partial vector
    step(1'b1, 16'hAAAA, 1'b0, 1'b1);
    step(1'b1, 16'hBBBB, 1'b0, 1'b1);
    step(1'b1, 16'hCCCC, 1'b0, 1'b1);
    do_reset(1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b1, 16'h6000, 1'b0, 1'b1);
    step(1'b1, 16'h6100, 1'b0, 1'b1);
    step(1'b1, 16'h6200, 1'b0, 1'b1);
    step(1'b1, 16'h6300, 1'b0, 1'b1);
    check_out("post_rst", 64'h6300_6200_6100_6000, 3'd4, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // Reset while a vector is held
    step(1'b1, 16'h7000, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    do_reset(1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // Randomized traffic against the group model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset(1);
      end else begin
        step($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 4) == 0,
             $urandom_range(0, 9) < 6);
      end
    end
    repeat (3) step(1'b0, 16'h0000, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
